// File: rtl/xmpl_dsp_dispatch.sv
// Command dispatcher that issues one operand pair at a time to a selected DSP
// channel, waits for that channel's result (or a timeout), and returns it.
module xmpl_dsp_dispatch #(
  parameter int NUM_CH = 3,
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int C_W    = 32,
  parameter int TO_W   = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [CH_W-1:0]       cmd_ch_i,
  input  logic [A_W-1:0]        cmd_a_i,
  input  logic [B_W-1:0]        cmd_b_i,
  output logic [NUM_CH-1:0]     ch_valid_o,
  input  logic [NUM_CH-1:0]     ch_ready_i,
  output logic [NUM_CH*A_W-1:0] ch_a_o,
  output logic [NUM_CH*B_W-1:0] ch_b_o,
  input  logic [NUM_CH-1:0]     ch_done_i,
  input  logic [NUM_CH*C_W-1:0] ch_c_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [C_W-1:0]        rsp_data_o,
  output logic [CH_W-1:0]       rsp_ch_o,
  output logic [1:0]            rsp_err_o,
  input  logic [TO_W-1:0]       timeout_i,
  output logic [1:0]            state_o,
  output logic [15:0]           done_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_CH  = 2'b10;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [NUM_CH-1:0]     ch_valid_q, ch_valid_d;
  logic [NUM_CH*A_W-1:0] ch_a_q, ch_a_d;
  logic [NUM_CH*B_W-1:0] ch_b_q, ch_b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [C_W-1:0]        rsp_data_q, rsp_data_d;
  logic [CH_W-1:0]       rsp_ch_q, rsp_ch_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [15:0]           done_cnt_q, done_cnt_d;

  logic                  sel_ready;
  logic                  sel_done;
  logic [C_W-1:0]        sel_c;
  logic [TO_W-1:0]       to_cnt_inc;

  // Only the latched channel's handshake and result are ever observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    sel_c     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_ready = ch_ready_i[k];
        sel_done  = ch_done_i[k];
        sel_c     = ch_c_i[k*C_W +: C_W];
      end
    end
  end

  assign to_cnt_inc = to_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    to_cnt_d    = to_cnt_q;
    cmd_ready_d = cmd_ready_q;
    ch_valid_d  = ch_valid_q;
    ch_a_d      = ch_a_q;
    ch_b_d      = ch_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ch_d    = rsp_ch_q;
    rsp_err_d   = rsp_err_q;
    done_cnt_d  = done_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          ch_d        = cmd_ch_i;
          cmd_ready_d = 1'b0;
          if (int'(cmd_ch_i) < NUM_CH) begin
            state_d = ISSUE;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (cmd_ch_i == CH_W'(k)) begin
                ch_valid_d[k]          = 1'b1;
                ch_a_d[k*A_W +: A_W]   = cmd_a_i;
                ch_b_d[k*B_W +: B_W]   = cmd_b_i;
              end
            end
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_ch_d    = cmd_ch_i;
            rsp_err_d   = ERR_BAD_CH;
          end
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          state_d    = WAIT;
          ch_valid_d = '0;
          ch_a_d     = '0;
          ch_b_d     = '0;
          to_cnt_d   = '0;
        end
      end
      WAIT: begin
        to_cnt_d = to_cnt_inc;
        // Done is checked first so a coincident timeout loses.
        if (sel_done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sel_c;
          rsp_ch_d    = ch_q;
          rsp_err_d   = ERR_OK;
        end else if ((timeout_i != '0) && (to_cnt_inc == timeout_i)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_ch_d    = ch_q;
          rsp_err_d   = ERR_TIMEOUT;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          if (rsp_err_q == ERR_OK) begin
            done_cnt_d = done_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      to_cnt_q    <= '0;
      cmd_ready_q <= 1'b1;
      ch_valid_q  <= '0;
      ch_a_q      <= '0;
      ch_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ch_q    <= '0;
      rsp_err_q   <= ERR_OK;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      to_cnt_q    <= to_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      ch_valid_q  <= ch_valid_d;
      ch_a_q      <= ch_a_d;
      ch_b_q      <= ch_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ch_q    <= rsp_ch_d;
      rsp_err_q   <= rsp_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign ch_valid_o  = ch_valid_q;
  assign ch_a_o      = ch_a_q;
  assign ch_b_o      = ch_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_ch_o    = rsp_ch_q;
  assign rsp_err_o   = rsp_err_q;
  assign state_o     = state_q;
  assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_xmpl_dsp_dispatch.sv
// Directed scoreboard bench for xmpl_dsp_dispatch with the default 3 channels.
module tb_xmpl_dsp_dispatch;

  localparam int NUM_CH = 3;
  localparam int A_W    = 16;
  localparam int B_W    = 16;
  localparam int C_W    = 32;
  localparam int TO_W   = 8;
  localparam int CH_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset_i;
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [CH_W-1:0]       cmd_ch_i;
  logic [A_W-1:0]        cmd_a_i;
  logic [B_W-1:0]        cmd_b_i;
  logic [NUM_CH-1:0]     ch_valid_o;
  logic [NUM_CH-1:0]     ch_ready_i;
  logic [NUM_CH*A_W-1:0] ch_a_o;
  logic [NUM_CH*B_W-1:0] ch_b_o;
  logic [NUM_CH-1:0]     ch_done_i;
  logic [NUM_CH*C_W-1:0] ch_c_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [C_W-1:0]        rsp_data_o;
  logic [CH_W-1:0]       rsp_ch_o;
  logic [1:0]            rsp_err_o;
  logic [TO_W-1:0]       timeout_i;
  logic [1:0]            state_o;
  logic [15:0]           done_cnt_o;

  always #5 clk = ~clk;

  xmpl_dsp_dispatch #(
    .NUM_CH (NUM_CH),
    .A_W    (A_W),
    .B_W    (B_W),
    .C_W    (C_W),
    .TO_W   (TO_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_ch_i    (cmd_ch_i),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .ch_valid_o  (ch_valid_o),
    .ch_ready_i  (ch_ready_i),
    .ch_a_o      (ch_a_o),
    .ch_b_o      (ch_b_o),
    .ch_done_i   (ch_done_i),
    .ch_c_i      (ch_c_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_ch_o    (rsp_ch_o),
    .rsp_err_o   (rsp_err_o),
    .timeout_i   (timeout_i),
    .state_o     (state_o),
    .done_cnt_o  (done_cnt_o)
  );

  typedef struct {
    logic [C_W-1:0]  data;
    logic [CH_W-1:0] ch;
    logic [1:0]      err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [C_W-1:0] d, input logic [CH_W-1:0] c, input logic [1:0] e);
    exp_t x;
    x.data = d;
    x.ch   = c;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic send_cmd(input logic [CH_W-1:0] ch, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    cmd_valid_i = 1'b1;
    cmd_ch_i    = ch;
    cmd_a_i     = a;
    cmd_b_i     = b;
    check("cmd_ready_before_accept", 64'(cmd_ready_o), 64'd1);
    tick();
    cmd_valid_i = 1'b0;
    cmd_a_i     = '0;
    cmd_b_i     = '0;
  endtask

  task automatic collect_rsp(input string tag);
    exp_t e;
    int   n = 0;
    while (!rsp_valid_o && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 64'(rsp_data_o), 64'(e.data));
      check({tag, "_ch"},   64'(rsp_ch_o),   64'(e.ch));
      check({tag, "_err"},  64'(rsp_err_o),  64'(e.err));
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({tag, "_idle_after"}, 64'(state_o), 64'd0);
    check({tag, "_cmd_ready_after"}, 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    reset_i     = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_ch_i    = '0;
    cmd_a_i     = '0;
    cmd_b_i     = '0;
    ch_ready_i  = '0;
    ch_done_i   = '0;
    ch_c_i      = '0;
    rsp_ready_i = 1'b0;
    timeout_i   = '0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    check("rst_state",     64'(state_o),     64'd0);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_ch_valid",  64'(ch_valid_o),  64'd0);
    check("rst_ch_a",      64'(ch_a_o),      64'd0);
    check("rst_ch_b",      64'(ch_b_o),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_data",  64'(rsp_data_o),  64'd0);
    check("rst_rsp_err",   64'(rsp_err_o),   64'd0);
    check("rst_done_cnt",  64'(done_cnt_o),  64'd0);

    // Basic transaction on channel 1, minimum latency.
    ch_ready_i = 3'b010;
    push_exp(32'hDEADBEEF, 2'd1, 2'b00);
    send_cmd(2'd1, 16'h1234, 16'h00FF);
    check("basic_issue_state", 64'(state_o),    64'd1);
    check("basic_ch_valid",    64'(ch_valid_o), 64'b010);
    check("basic_ch_a",        64'(ch_a_o),     64'h0000_1234_0000);
    check("basic_ch_b",        64'(ch_b_o),     64'h0000_00FF_0000);
    check("basic_cmd_ready",   64'(cmd_ready_o), 64'd0);
    ch_done_i = 3'b010;
    ch_c_i[1*C_W +: C_W] = 32'hDEADBEEF;
    tick();
    check("basic_wait_state", 64'(state_o),    64'd2);
    check("basic_valid_drop", 64'(ch_valid_o), 64'd0);
    check("basic_no_rsp_yet", 64'(rsp_valid_o), 64'd0);
    tick();
    check("basic_rsp_at_3",   64'(rsp_valid_o), 64'd1);
    ch_done_i = '0;
    collect_rsp("basic");
    check("basic_done_cnt", 64'(done_cnt_o), 64'd1);

    // Timeout after exactly five WAIT cycles.
    timeout_i  = 8'd5;
    ch_ready_i = 3'b001;
    push_exp(32'h0, 2'd0, 2'b01);
    send_cmd(2'd0, 16'h1111, 16'h2222);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_still_wait", 64'(state_o), 64'd2);
    end
    tick();
    check("to_resp_state", 64'(state_o), 64'd3);
    collect_rsp("timeout");
    check("to_done_cnt", 64'(done_cnt_o), 64'd1);
    timeout_i = '0;

    // Out-of-range channel returns an error response directly.
    push_exp(32'h0, 2'd3, 2'b10);
    send_cmd(2'd3, 16'hAAAA, 16'hBBBB);
    check("badch_state",    64'(state_o),     64'd3);
    check("badch_ch_valid", 64'(ch_valid_o),  64'd0);
    check("badch_rsp",      64'(rsp_valid_o), 64'd1);
    collect_rsp("badch");
    check("badch_done_cnt", 64'(done_cnt_o), 64'd1);

    // Backpressure on both the channel issue and the response.
    ch_ready_i = 3'b000;
    push_exp(32'hCAFEF00D, 2'd0, 2'b00);
    send_cmd(2'd0, 16'hA5A5, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      check("bp_issue_state", 64'(state_o),     64'd1);
      check("bp_ch_valid",    64'(ch_valid_o),  64'b001);
      check("bp_ch_a",        64'(ch_a_o),      64'h0000_0000_A5A5);
      check("bp_ch_b",        64'(ch_b_o),      64'h0000_0000_5A5A);
      check("bp_cmd_ready",   64'(cmd_ready_o), 64'd0);
      tick();
    end
    ch_ready_i = 3'b001;
    tick();
    check("bp_wait_state", 64'(state_o), 64'd2);
    ch_done_i = 3'b001;
    ch_c_i[0 +: C_W] = 32'hCAFEF00D;
    tick();
    ch_done_i = '0;
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check("bp_rsp_data",  64'(rsp_data_o),  64'hCAFEF00D);
      check("bp_rsp_err",   64'(rsp_err_o),   64'd0);
      check("bp_rsp_ch",    64'(rsp_ch_o),    64'd0);
      check("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
      tick();
    end
    collect_rsp("bp");
    check("bp_done_cnt", 64'(done_cnt_o), 64'd2);

    // Done and timeout land in the same cycle: done wins.
    timeout_i  = 8'd3;
    ch_ready_i = 3'b100;
    push_exp(32'h12345678, 2'd2, 2'b00);
    send_cmd(2'd2, 16'h0F0F, 16'hF0F0);
    tick();
    tick();
    check("tie_wait1", 64'(state_o), 64'd2);
    tick();
    check("tie_wait2", 64'(state_o), 64'd2);
    ch_done_i = 3'b100;
    ch_c_i[2*C_W +: C_W] = 32'h12345678;
    tick();
    ch_done_i = '0;
    collect_rsp("tie");
    check("tie_done_cnt", 64'(done_cnt_o), 64'd3);
    timeout_i = '0;

    // Done on a non-selected channel is ignored.
    ch_ready_i = 3'b001;
    push_exp(32'h00000077, 2'd0, 2'b00);
    send_cmd(2'd0, 16'h0001, 16'h0002);
    tick();
    ch_done_i = 3'b100;
    ch_c_i[2*C_W +: C_W] = 32'hFFFFFFFF;
    tick();
    check("other_done_wait1", 64'(state_o), 64'd2);
    tick();
    check("other_done_wait2", 64'(state_o), 64'd2);
    ch_done_i = 3'b001;
    ch_c_i[0 +: C_W] = 32'h00000077;
    tick();
    ch_done_i = '0;
    collect_rsp("other_done");
    check("other_done_cnt", 64'(done_cnt_o), 64'd4);

    // Reset while waiting abandons the command.
    ch_ready_i = 3'b010;
    send_cmd(2'd1, 16'h4444, 16'h5555);
    tick();
    check("rstw_wait_state", 64'(state_o), 64'd2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rstw_state",     64'(state_o),     64'd0);
    check("rstw_ch_valid",  64'(ch_valid_o),  64'd0);
    check("rstw_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rstw_done_cnt",  64'(done_cnt_o),  64'd0);
    ch_done_i = 3'b010;
    ch_c_i[1*C_W +: C_W] = 32'h99999999;
    tick();
    tick();
    ch_done_i = '0;
    check("rstw_late_state",     64'(state_o),     64'd0);
    check("rstw_late_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rstw_cmd_ready",      64'(cmd_ready_o), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/xmpl_dsp_dispatch.md
XMPL_DSP_DISPATCH -- requirements
Module: xmpl_dsp_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of DSP accelerator channels (1..16).
REQ-002 SHALL have parameter A_W, default 16, operand A width.
REQ-003 SHALL have parameter B_W, default 16, operand B width.
REQ-004 SHALL have parameter C_W, default 32, result width.
REQ-005 SHALL have parameter TO_W, default 8, timeout counter width; CH_W = max(1, clog2(NUM_CH)).
REQ-006 SHALL have ports: clk_i  in  1  sole clock, rising edge; reset_i  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_ch_i in CH_W; cmd_a_i in A_W; cmd_b_i in B_W: command request.
REQ-008 SHALL have ports: ch_valid_o out NUM_CH; ch_ready_i in NUM_CH; ch_a_o out NUM_CH*A_W; ch_b_o out NUM_CH*B_W: per-channel issue, channel k at slice k.
REQ-009 SHALL have ports: ch_done_i in NUM_CH; ch_c_i in NUM_CH*C_W: per-channel completion pulse and result.
REQ-010 SHALL have ports: rsp_valid_o out 1; rsp_ready_i in 1; rsp_data_o out C_W; rsp_ch_o out CH_W; rsp_err_o out 2: response.
REQ-011 SHALL have ports: timeout_i in TO_W (0 = timeout disabled); state_o out 2; done_cnt_o out 16.

Function
REQ-012 SHALL implement FSM IDLE(00), ISSUE(01), WAIT(10), RESP(11), driven on state_o.
REQ-013 SHALL assert cmd_ready_o only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o, latching ch/a/b.
REQ-014 SHALL, on acceptance with cmd_ch_i < NUM_CH, go IDLE->ISSUE; with cmd_ch_i >= NUM_CH, go IDLE->RESP with rsp_err_o=10, rsp_data_o=0, no channel issued.
REQ-015 SHALL in ISSUE drive ch_valid_o one-hot at latched channel, latched operands on that channel's slices, all other slices 0.
REQ-016 SHALL hold ch_valid_o and operands stable until ch_ready_i[ch]=1, then go ISSUE->WAIT; ch_ready_i of other channels ignored.
REQ-017 SHALL in WAIT clear the timeout counter on entry and increment it by 1 each WAIT cycle.
REQ-018 SHALL on ch_done_i[ch]=1 in WAIT capture ch_c_i slice ch into rsp_data_o, set rsp_err_o=00, go WAIT->RESP.
REQ-019 SHALL, when timeout_i != 0 and counter reaches timeout_i without done, go WAIT->RESP with rsp_err_o=01, rsp_data_o=0.
REQ-020 SHALL give done priority over timeout when both occur in the same cycle.
REQ-021 SHALL ignore ch_done_i in IDLE, ISSUE, RESP and on non-selected channels.
REQ-022 SHALL in RESP assert rsp_valid_o with rsp_data_o/rsp_ch_o/rsp_err_o stable until rsp_ready_i=1, then go to IDLE.
REQ-023 SHALL increment done_cnt_o (mod 2^16) on each response handshake with rsp_err_o=00.
REQ-024 SHALL achieve minimum latency of 3 cycles acceptance-edge to rsp_valid_o when ch_ready_i and ch_done_i are already high.
REQ-025 SHALL sample timeout_i continuously in WAIT (changes take effect next compare).

Reset
REQ-026 SHALL on reset_i=1 at a clock edge enter IDLE regardless of current state, abandoning any in-flight command.
REQ-027 SHALL reset cmd_ready_o=1 after reset release, ch_valid_o=0, ch_a_o=0, ch_b_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_ch_o=0, rsp_err_o=00, state_o=00, done_cnt_o=0, timeout counter 0.

Verification
REQ-028 SHALL cover: cmd ch=1 a=0x1234 b=0x00FF, ch_ready_i[1]=1, ch_done_i[1] next cycle with c=0xDEADBEEF -> rsp_data_o=0xDEADBEEF, rsp_ch_o=1, err=00, done_cnt_o=1, rsp_valid 3 cycles after accept.
REQ-029 SHALL cover: timeout_i=5, no done -> rsp_err_o=01, rsp_data_o=0 after 5 WAIT cycles; done_cnt_o unchanged.
REQ-030 SHALL cover: cmd_ch_i=3 with NUM_CH=3 -> ch_valid_o stays 0, rsp_err_o=10 one cycle after accept.
REQ-031 SHALL cover: ch_ready_i[0] held low 4 cycles, rsp_ready_i low 3 cycles -> ch_valid_o/operands and rsp outputs stable throughout; cmd_ready_o=0 until response handshake.
REQ-032 SHALL cover: done and timeout same cycle (timeout_i=3, done on 3rd WAIT cycle) -> err=00 with data; ch_done_i[2] while channel 0 selected -> ignored.
REQ-033 SHALL cover: reset_i asserted in WAIT -> next cycle state_o=00, ch_valid_o=0, rsp_valid_o=0, later done pulse ignored.
